uart_rx_ctrl: RTL
=================

// Module: uart_rx_ctrl
// PURPOSE
//   Receive-path controller of the UART RX. Tracks frame position with an oversampling edge
//   counter and a bit counter, and drives all RX datapath stages:
//     - sampler: dat_samp_en, edge_cnt
//     - deserializer: deser_en, one pulse per data bit
//     - start/parity/stop checkers: *_chk_en
//   Qualifies the finished byte with data_valid. Sits between the RX_IN line and the datapath.
// PARAMETERS
//   DATA_W      8  data bits per frame, LSB first
//   PRESCALE_W  6  width of Prescale and edge_cnt
// PORTS
//   CLK          in   1           system clock, rising edge
//   RST          in   1           asynchronous reset, active-low
//   RX_IN        in   1           serial line, idle high
//   Prescale     in   PRESCALE_W  oversampling ratio; legal 8/16/32
//   PAR_EN       in   1           1 = frame carries a parity bit
//   sampled_bit  in   1           majority-voted bit from the sampler
//   par_err      in   1           parity checker result; valid while par_chk_en=1
//   stp_err      in   1           stop checker result; valid while stp_chk_en=1
//   edge_cnt     out  PRESCALE_W  oversample index within the current bit, 0..Prescale-1
//   dat_samp_en  out  1           sampler enable
//   deser_en     out  1           shift strobe to the deserializer
//   strt_chk_en  out  1           start-bit check strobe
//   par_chk_en   out  1           parity check strobe
//   stp_chk_en   out  1           stop check strobe
//   data_valid   out  1           1-cycle pulse: byte on the deserializer output is good
//   busy         out  1           1 while not in IDLE
// BEHAVIOUR
//   Reset (RST=0, any time, mid-frame included):
//     - state=IDLE, counters 0, every output 0
//     - the partial frame is discarded and no pulses follow.
//   States: IDLE, START, DATA, PARITY, STOP. All outputs are registered.
//   "Bit end" = the cycle where edge_cnt == Prescale-1.
//     - edge_cnt increments every cycle outside IDLE and wraps to 0 at bit end.
//   IDLE:
//     - edge_cnt and bit_cnt held at 0.
//     - RX_IN=0 -> START. That cycle is edge 0 of the start bit.
//     - Prescale is latched here; mid-frame Prescale changes are ignored.
//     - Latched values below 4 are clamped to 4.
//   dat_samp_en = busy.
//   Check strobes are 1-cycle pulses at bit end; the checker result is used in that same cycle.
//   START at bit end: strt_chk_en=1.
//     - sampled_bit=1 (glitch) -> IDLE, no data_valid.
//     - Otherwise -> DATA with bit_cnt=0.
//   DATA at bit end: deser_en=1, bit_cnt++.
//     - After DATA_W pulses: PAR_EN ? PARITY : STOP.
//     - Exactly DATA_W deser_en pulses per accepted frame.
//   PARITY at bit end: par_chk_en=1.
//     - par_err=1 -> IDLE.
//     - Otherwise -> STOP.
//   STOP at bit end: stp_chk_en=1, then -> IDLE.
//     - data_valid pulses the following cycle only if stp_err=0 and no earlier error in the frame.
//   Back-to-back frames:
//     - IDLE may see RX_IN=0 in the cycle data_valid pulses; START is entered with no dead cycle.
//   PAR_EN is sampled on START entry; mid-frame changes are ignored.
// CONFIGURATION
//   UART_RX_ERR_CNT_EN defined:
//     - Adds output err_cnt[7:0], reset 0.
//     - Increments by 1 on each glitch, parity error or stop error; saturates at 8'hFF.
//   Not defined:
//     - No err_cnt port and no counter logic; all other behaviour is identical.
// STRUCTURE
//   Package uart_rx_pkg:
//     - state enum (IDLE, START, DATA, PARITY, STOP)
//     - PRESCALE_MIN=4
//     - DATA_W default
//   Sub-module uart_rx_edge_bit_cnt: edge_cnt/bit_cnt with enable, wrap and clear.
//   The FSM and output registers live in uart_rx_ctrl.
// TESTING
//   1) Prescale=8, PAR_EN=0, byte 0xA5 at 8 clk/bit
//      -> 8 deser_en pulses 8 clk apart, stp_chk_en once, data_valid 1 cycle after it.
//   2) Prescale=16, PAR_EN=1, even parity, 0x3C, par_err=0
//      -> par_chk_en once at bit 9 end, data_valid=1.
//      Same frame with par_err=1 -> no stp_chk_en, no data_valid, busy drops.
//   3) RX_IN low 3 clk then high, sampled_bit=1 at start bit end
//      -> strt_chk_en pulse, IDLE, zero deser_en.
//   4) stp_err=1 at stop bit end -> no data_valid.
//      Next frame starts in the cycle right after and completes normally.
//   5) RST low in DATA after 4 deser_en pulses -> all outputs 0 next edge, IDLE.
//      A full frame after release is accepted.
//   6) With UART_RX_ERR_CNT_EN: 300 glitch frames -> err_cnt=0xFF.
//      Prescale=32 frame with PAR_EN toggled mid-frame -> frame decoded with its latched settings.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART RX receive path.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam int PRESCALE_MIN = 4;
  localparam int DATA_W_DEF   = 8;

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Line, configuration, checker-result and strobe signals between the RX controller and its datapath.
// err_cnt exists only when UART_RX_ERR_CNT_EN is defined.
interface uart_rx_ctrl_if #(
  parameter int PRESCALE_W = 6
);
  logic                  RX_IN;
  logic [PRESCALE_W-1:0] Prescale;
  logic                  PAR_EN;
  logic                  sampled_bit;
  logic                  par_err;
  logic                  stp_err;
  logic [PRESCALE_W-1:0] edge_cnt;
  logic                  dat_samp_en;
  logic                  deser_en;
  logic                  strt_chk_en;
  logic                  par_chk_en;
  logic                  stp_chk_en;
  logic                  data_valid;
  logic                  busy;
`ifdef UART_RX_ERR_CNT_EN
  logic [7:0]            err_cnt;
`endif

  modport master (
`ifdef UART_RX_ERR_CNT_EN
    output err_cnt,
`endif
    input  RX_IN, Prescale, PAR_EN, sampled_bit, par_err, stp_err,
    output edge_cnt, dat_samp_en, deser_en, strt_chk_en, par_chk_en,
    output stp_chk_en, data_valid, busy
  );

  modport slave (
`ifdef UART_RX_ERR_CNT_EN
    input  err_cnt,
`endif
    output RX_IN, Prescale, PAR_EN, sampled_bit, par_err, stp_err,
    input  edge_cnt, dat_samp_en, deser_en, strt_chk_en, par_chk_en,
    input  stp_chk_en, data_valid, busy
  );

endinterface

// File: rtl/uart_rx_edge_bit_cnt.sv
// Oversample edge counter (wraps at top) and data-bit counter for the RX controller.
module uart_rx_edge_bit_cnt #(
  parameter int PRESCALE_W = 6,
  parameter int BIT_W      = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  clr,
  input  logic                  start,
  input  logic                  en,
  input  logic [PRESCALE_W-1:0] top,
  input  logic                  bit_inc,
  output logic [PRESCALE_W-1:0] edge_cnt,
  output logic [BIT_W-1:0]      bit_cnt
);

  // start loads edge 1: the detecting IDLE cycle already counted as edge 0
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (clr) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (start) begin
      edge_cnt <= PRESCALE_W'(1);
      bit_cnt  <= '0;
    end else begin
      if (en)
        edge_cnt <= (edge_cnt == top) ? '0 : edge_cnt + PRESCALE_W'(1);
      if (bit_inc)
        bit_cnt <= bit_cnt + BIT_W'(1);
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART RX receive-path controller: frame FSM with registered strobes for sampler, deserializer and checkers.
// Defining UART_RX_ERR_CNT_EN adds a saturating 8-bit frame error counter (err_cnt).
module uart_rx_ctrl
  import uart_rx_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int PRESCALE_W = 6
) (
  input  logic           CLK,
  input  logic           RST,
  uart_rx_ctrl_if.master rx
);

  localparam int BIT_W = $clog2(DATA_W + 1);
  typedef logic [PRESCALE_W-1:0] pre_t;

  function automatic pre_t clamp_prescale(input pre_t p);
    return (p < pre_t'(PRESCALE_MIN)) ? pre_t'(PRESCALE_MIN) : p;
  endfunction

  state_t           state, state_nxt;
  pre_t             prescale_q, prescale_nxt;
  logic             par_en_q, par_en_nxt;
  pre_t             edge_cnt, top;
  logic [BIT_W-1:0] bit_cnt;
  logic             cnt_clr, cnt_start, cnt_en, bit_inc;
  logic             bit_end, pre_end;
  logic             deser_nxt, strt_nxt, par_nxt, stp_nxt, dv_nxt, busy_nxt;
  logic             deser_q, strt_q, par_q, stp_q, dv_q, busy_q;

  assign top     = prescale_q - pre_t'(1);
  assign bit_end = (edge_cnt == top);
  assign pre_end = (edge_cnt == pre_t'(prescale_q - pre_t'(2)));

  uart_rx_edge_bit_cnt #(
    .PRESCALE_W (PRESCALE_W),
    .BIT_W      (BIT_W)
  ) u_cnt (
    .CLK      (CLK),
    .RST      (RST),
    .clr      (cnt_clr),
    .start    (cnt_start),
    .en       (cnt_en),
    .top      (top),
    .bit_inc  (bit_inc),
    .edge_cnt (edge_cnt),
    .bit_cnt  (bit_cnt)
  );

  // Strobes are armed one edge early (pre_end) so their registered copy lands on bit end
  always_comb begin
    state_nxt    = state;
    prescale_nxt = prescale_q;
    par_en_nxt   = par_en_q;
    cnt_clr      = 1'b0;
    cnt_start    = 1'b0;
    cnt_en       = 1'b0;
    bit_inc      = 1'b0;
    deser_nxt    = 1'b0;
    strt_nxt     = 1'b0;
    par_nxt      = 1'b0;
    stp_nxt      = 1'b0;
    dv_nxt       = 1'b0;
    case (state)
      IDLE: begin
        cnt_clr      = 1'b1;
        prescale_nxt = clamp_prescale(rx.Prescale);
        if (!rx.RX_IN) begin
          state_nxt  = START;
          cnt_clr    = 1'b0;
          cnt_start  = 1'b1;
          par_en_nxt = rx.PAR_EN;
        end
      end
      START: begin
        cnt_en   = 1'b1;
        strt_nxt = pre_end;
        if (bit_end)
          state_nxt = rx.sampled_bit ? IDLE : DATA;
      end
      DATA: begin
        cnt_en    = 1'b1;
        deser_nxt = pre_end;
        if (bit_end) begin
          bit_inc = 1'b1;
          if (bit_cnt == BIT_W'(DATA_W - 1))
            state_nxt = par_en_q ? PARITY : STOP;
        end
      end
      PARITY: begin
        cnt_en  = 1'b1;
        par_nxt = pre_end;
        if (bit_end)
          state_nxt = rx.par_err ? IDLE : STOP;
      end
      STOP: begin
        cnt_en  = 1'b1;
        stp_nxt = pre_end;
        if (bit_end) begin
          state_nxt = IDLE;
          dv_nxt    = !rx.stp_err;
        end
      end
      default: state_nxt = IDLE;
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= IDLE;
      prescale_q <= pre_t'(PRESCALE_MIN);
      par_en_q   <= 1'b0;
      deser_q    <= 1'b0;
      strt_q     <= 1'b0;
      par_q      <= 1'b0;
      stp_q      <= 1'b0;
      dv_q       <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state      <= state_nxt;
      prescale_q <= prescale_nxt;
      par_en_q   <= par_en_nxt;
      deser_q    <= deser_nxt;
      strt_q     <= strt_nxt;
      par_q      <= par_nxt;
      stp_q      <= stp_nxt;
      dv_q       <= dv_nxt;
      busy_q     <= busy_nxt;
    end
  end

  assign rx.edge_cnt    = edge_cnt;
  assign rx.dat_samp_en = busy_q;
  assign rx.deser_en    = deser_q;
  assign rx.strt_chk_en = strt_q;
  assign rx.par_chk_en  = par_q;
  assign rx.stp_chk_en  = stp_q;
  assign rx.data_valid  = dv_q;
  assign rx.busy        = busy_q;

`ifdef UART_RX_ERR_CNT_EN
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic       frame_err;
  logic [7:0] err_q;

  assign frame_err = bit_end && ((state == START  && rx.sampled_bit) ||
                                 (state == PARITY && rx.par_err)     ||
                                 (state == STOP   && rx.stp_err));

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)
      err_q <= 8'h00;
    else if (frame_err)
      err_q <= sat_inc(err_q);
  end

  assign rx.err_cnt = err_q;
`endif

endmodule
